// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory responder
//
// Purpose : state encoding, data-path constants and the request error check
//           used by dmem_responder and dmem_array.
// Contents: DATA_WIDTH, NUM_LANES, state_e, addr_err()
package dmem_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_LANES  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // A request errors when it is not word aligned or when it addresses
   // anything beyond the 2**aw words of storage.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with per-byte write enables
//
// Purpose : 2**ADDR_WIDTH words of DATA_WIDTH bits. Writes happen on the
//           rising edge for each enabled byte lane. The read port is
//           asynchronous; the responder samples it on the same edge a write
//           commits, so a read of the word being written yields the old data.
// Ports   : clk_i   - clock
//           we_i    - write enable
//           be_i    - byte-lane enables
//           addr_i  - word address
//           wdata_i - write data
//           rdata_o - read data (current contents of addr_i)
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [NUM_LANES-1:0]  be_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (we_i && be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with programmable latency
//
// Purpose : accepts one load/store at a time, performs it on the accept edge
//           and presents the response LATENCY cycles later (LATENCY 1..15).
// Ports   : clk_i, rst_i (async, active high)
//           req_valid_i/req_ready_o, req_we_i, req_addr_i (byte address),
//           req_wdata_i, req_be_i
//           rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_err_o
//           All outputs come straight from registers.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [31:0]           req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [NUM_LANES-1:0]  req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o
);

   localparam logic [3:0] WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   logic                  accept;
   logic                  req_err;
   logic                  arr_we;
   logic [DATA_WIDTH-1:0] arr_rdata;

   // req_ready_q is only ever set while in IDLE, so it alone qualifies accept.
   assign accept  = req_valid_i && req_ready_q;
   assign req_err = addr_err(req_addr_i, ADDR_WIDTH);
   assign arr_we  = accept && req_we_i && !req_err;

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (arr_we),
      .be_i    (req_be_i),
      .addr_i  (req_addr_i[ADDR_WIDTH+1:2]),
      .wdata_i (req_wdata_i),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  req_ready_q <= 1'b0;
                  rsp_err_q   <= req_err;
                  // Pre-write contents are sampled here; stores and errors return 0.
                  rsp_rdata_q <= (req_we_i || req_err) ? '0 : arr_rdata;
                  if (LATENCY == 1) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= WAIT_INIT;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. Accepts one load/store request at a time over a valid/ready handshake.
- Performs the access on a word-addressed storage array with byte enables, then returns a response after a programmable latency.
- Sits between the Mem stage (initiator) and backing storage. It lets the core be exercised against multi-cycle memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; storage depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, data word width; fixed at 32 for RV32.
- LATENCY, 2, cycles from the accept edge to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i enables byte lane i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; req_ready=0 while rst is held, 1 from the first edge after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Storage contents are not reset; unwritten words read as X.
- Accept: occurs on a rising edge with req_valid && req_ready. The request fields are sampled on that edge (cycle T).
- Error check at accept:
  - err = (req_addr[1:0] != 0) or (req_addr[31:ADDR_WIDTH+2] != 0).
  - An erroring store writes nothing.
  - An erroring load returns rdata=0.
- Store: the enabled byte lanes of word req_addr[ADDR_WIDTH+1:2] are written on the accept edge. req_be=0 is legal: no write, normal response.
- Load: the word is read on the accept edge into a holding register. The full word is returned; req_be is ignored for loads.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on accept, if LATENCY==1 go to RESP, else go to WAIT with counter=LATENCY-2.
  - WAIT: if counter==0 go to RESP, else decrement the counter.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err stable. When rsp_ready=1, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
- Timing:
  - rsp_valid is first high in cycle T+LATENCY.
  - After the response handshake edge, req_ready is high in the next cycle.
  - Maximum throughput is one request per LATENCY+1 cycles.
- Backpressure: rsp_valid holds indefinitely while rsp_ready=0, and no new request is accepted. rsp_ready while not in RESP is ignored.
- Requests in WAIT/RESP: req_valid is ignored (req_ready=0). The initiator must hold the request until it is accepted; the responder does not check this.
- Reset mid-operation: any in-flight response is discarded and the FSM returns to IDLE. A store already committed on its accept edge stays committed.
- The outputs rsp_* and req_ready are registered or decoded from state only. There is no combinational path from any input to any output.

Decomposition:
- Package dmem_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the DATA_WIDTH and byte-lane count constants;
  - the error-check function (alignment and range).
- Sub-module dmem_array: word storage with byte-enable write and read on the same edge. A read of the word being written returns the old data. Ports: clk, we, be, addr, wdata, rdata.
- dmem_responder contains the FSM, the latency counter and the response registers.

Test Plan:
- Reset then idle: hold rst for 3 cycles. Required: rsp_valid=0 and req_ready=0 during reset; req_ready=1 in the first cycle after release; no response with no request.
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF, be=4'hF; rsp_valid at T+2 with rsp_err=0 and rdata=0.
  - Load addr 0x10; rsp_rdata=0xDEADBEEF at T+2.
- Byte-enable merge: store 0x11223344 to 0x20 with be=F, then store 0xAABBCCDD with be=4'b0101. Load of 0x20 returns 0x11BB33DD.
- Errors:
  - Load from 0x21 gives rsp_err=1, rdata=0.
  - Store to 0x1000 (ADDR_WIDTH=10) gives rsp_err=1 and the array is unchanged; a load of 0x0 afterward returns the prior value.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP. rsp_valid and rsp_rdata stay stable, and req_ready stays 0 throughout. Releasing rsp_ready gives req_ready=1 on the next cycle.
- Mid-operation reset and LATENCY=1:
  - Assert rst in WAIT: rsp_valid never rises and the FSM returns to IDLE.
  - With LATENCY=1, back-to-back loads with rsp_ready tied high are accepted every 2 cycles.
